// File: rtl/uart_pkg.sv
// Shared types and helpers for the word-to-byte UART transmit path.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_BUSY,
    WAIT_READY
  } tx_state_t;

  function automatic int nbytes(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with extra-MSB pointers, occupancy and a sticky
// overflow flag for pushes attempted while full.
module sync_fifo #(
  parameter int WIDTH      = 33,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      pop_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                push_ok;
  logic                pop_ok;

  assign full_o     = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                      (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign overflow_o = overflow_q;
  assign pop_data_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // Fullness is judged on the current pointers, so a pop in the same cycle
  // does not make room for a push.
  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok)          wr_ptr_d   = wr_ptr_q + PTR_ONE;
      if (pop_ok)           rd_ptr_d   = rd_ptr_q + PTR_ONE;
      if (push_i && full_o) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_word_tx_fifo.sv
// Queues words from the execution stage and serialises each one into bytes
// for a byte-wide UART sender, with flush, occupancy and overflow reporting.
module uart_word_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 3,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_byte_only,
  input  logic                  wr_enable,
  output logic                  wr_ready,
  input  logic                  sender_ready,
  output logic [BYTE_W-1:0]     sender_data,
  output logic                  sender_enable,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  busy,
  output logic                  overflow,
  output tx_state_t             dbg_state
);

  localparam int NBYTES  = nbytes(DATA_WIDTH);
  localparam int CNT_W   = $clog2(NBYTES + 1);
  localparam int ENTRY_W = DATA_WIDTH + 1;

  // Handshakes: a word is taken on any edge where wr_enable && wr_ready; a
  // byte is handed over by a one-cycle sender_enable pulse, only when
  // sender_ready was high, and the next byte waits for ready to fall and rise.
  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      left_q, left_d;
  logic [BYTE_W-1:0]     data_q, data_d;
  logic                  enable_q, enable_d;

  logic [ENTRY_W-1:0]    fifo_rdata;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic                  entry_bo;
  logic [DATA_WIDTH-1:0] entry_data;
  logic [BYTE_W-1:0]     cur_byte;
  logic [DATA_WIDTH-1:0] shreg_next;

  sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (reset_n),
    .clear_i     (flush),
    .push_i      (wr_enable),
    .push_data_i ({wr_byte_only, wr_data}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count),
    .overflow_o  (overflow)
  );

  assign entry_bo   = fifo_rdata[DATA_WIDTH];
  assign entry_data = fifo_rdata[DATA_WIDTH-1:0];
  assign cur_byte   = MSB_FIRST ? shreg_q[DATA_WIDTH-1 -: BYTE_W] : shreg_q[BYTE_W-1:0];
  assign shreg_next = MSB_FIRST ? (shreg_q << BYTE_W) : (shreg_q >> BYTE_W);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    left_d   = left_q;
    data_d   = data_q;
    enable_d = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        fifo_pop = 1'b1;
        // A byte-only word in MSB-first mode is parked at the top so the
        // normal shift path still emits data[7:0].
        shreg_d  = (entry_bo && MSB_FIRST) ? (entry_data << (DATA_WIDTH - BYTE_W))
                                           : entry_data;
        left_d   = entry_bo ? CNT_W'(1) : CNT_W'(NBYTES);
        state_d  = ISSUE;
      end
      ISSUE: begin
        if (sender_ready) begin
          data_d   = cur_byte;
          enable_d = 1'b1;
          shreg_d  = shreg_next;
          left_d   = left_q - 1'b1;
          state_d  = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!sender_ready) state_d = WAIT_READY;
      end
      WAIT_READY: begin
        if (sender_ready) begin
          if (left_q != '0)     state_d = ISSUE;
          else if (!fifo_empty) state_d = LOAD;
          else                  state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      data_d   = data_q;
      enable_d = 1'b0;
      fifo_pop = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      left_q   <= '0;
      data_q   <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      left_q   <= left_d;
      data_q   <= data_d;
      enable_q <= enable_d;
    end
  end

  assign wr_ready      = !fifo_full;
  assign sender_data   = data_q;
  assign sender_enable = enable_q;
  assign busy          = (state_q != IDLE) || !fifo_empty;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_word_tx_fifo.sv
// Bench for uart_word_tx_fifo: an MSB-first and an LSB-first instance share
// one stimulus stream and a reactive sender model; bytes go to per-order queues.
module tb_uart_word_tx_fifo;
  import uart_pkg::*;

  localparam int DW = 32;
  localparam int DL = 2;

  logic          CLK = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_byte_only = 1'b0;
  logic          wr_enable = 1'b0;
  logic          sender_ready = 1'b0;

  logic          a_wr_ready, b_wr_ready;
  logic [7:0]    a_sender_data, b_sender_data;
  logic          a_sender_enable, b_sender_enable;
  logic [DL:0]   a_count, b_count;
  logic          a_busy, b_busy, a_overflow, b_overflow;
  tx_state_t     a_dbg_state, b_dbg_state;

  uart_word_tx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .MSB_FIRST(1'b1)) u_msb (
    .CLK(CLK), .reset_n(reset_n), .flush(flush), .wr_data(wr_data),
    .wr_byte_only(wr_byte_only), .wr_enable(wr_enable), .wr_ready(a_wr_ready),
    .sender_ready(sender_ready), .sender_data(a_sender_data),
    .sender_enable(a_sender_enable), .count(a_count), .busy(a_busy),
    .overflow(a_overflow), .dbg_state(a_dbg_state)
  );

  uart_word_tx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(CLK), .reset_n(reset_n), .flush(flush), .wr_data(wr_data),
    .wr_byte_only(wr_byte_only), .wr_enable(wr_enable), .wr_ready(b_wr_ready),
    .sender_ready(sender_ready), .sender_data(b_sender_data),
    .sender_enable(b_sender_enable), .count(b_count), .busy(b_busy),
    .overflow(b_overflow), .dbg_state(b_dbg_state)
  );

  // Clock / reset block.
  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         pulse_cnt = 0;
  int         first_pulse_cyc = -1;
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  bit         hold_ready = 1'b0;
  int         snd_gap = 0;
  int         max_gap = 3;
  logic       prev_a_en = 1'b0;
  logic       prev_b_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Sender model: ready falls after it sees a start pulse and comes back later.
  always @(posedge CLK) begin
    if (a_sender_enable) begin
      snd_gap      <= int'($urandom_range(max_gap, 1));
      sender_ready <= 1'b0;
    end else if (snd_gap > 0) begin
      snd_gap      <= snd_gap - 1;
      sender_ready <= 1'b0;
    end else begin
      sender_ready <= !hold_ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every start pulse must carry the next expected byte.
  always @(negedge CLK) begin
    prev_a_en <= a_sender_enable;
    prev_b_en <= b_sender_enable;
    if (a_sender_enable) begin
      pulse_cnt <= pulse_cnt + 1;
      if (first_pulse_cyc < 0) first_pulse_cyc <= cyc;
      chk("a_pulse_width", {31'd0, prev_a_en}, 32'd0);
      total++;
      assert (exp_a_q.size() != 0) else begin
        bad++;
        $error("FAIL a_unexpected_pulse: observed data=%0h expected=no pulse", a_sender_data);
      end
      if (exp_a_q.size() != 0) chk("a_byte", {24'd0, a_sender_data}, {24'd0, exp_a_q.pop_front()});
    end
    if (b_sender_enable) begin
      chk("b_pulse_width", {31'd0, prev_b_en}, 32'd0);
      total++;
      assert (exp_b_q.size() != 0) else begin
        bad++;
        $error("FAIL b_unexpected_pulse: observed data=%0h expected=no pulse", b_sender_data);
      end
      if (exp_b_q.size() != 0) chk("b_byte", {24'd0, b_sender_data}, {24'd0, exp_b_q.pop_front()});
    end
  end

  // Driver tasks.
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_push(input logic [DW-1:0] d, input logic bo);
    if (bo) begin
      exp_a_q.push_back(d[7:0]);
      exp_b_q.push_back(d[7:0]);
    end else begin
      for (int i = DW / 8 - 1; i >= 0; i--) exp_a_q.push_back(d[8*i +: 8]);
      for (int i = 0; i < DW / 8; i++) exp_b_q.push_back(d[8*i +: 8]);
    end
  endtask

  task automatic write_raw(input logic [DW-1:0] d, input logic bo);
    wr_data      = d;
    wr_byte_only = bo;
    wr_enable    = 1'b1;
    step();
    wr_enable    = 1'b0;
  endtask

  task automatic write_word(input logic [DW-1:0] d, input logic bo);
    int n = 0;
    while (!a_wr_ready && n < 300) begin
      step();
      n++;
    end
    chk("write_ready_wait", {31'd0, a_wr_ready}, 32'd1);
    if (a_wr_ready) begin
      model_push(d, bo);
      write_raw(d, bo);
    end
  endtask

  task automatic check_status(input string tag, input int cnt, input logic rdy,
                              input logic ovf, input logic bsy);
    chk({tag, "_a_count"}, 32'(a_count), 32'(cnt));
    chk({tag, "_b_count"}, 32'(b_count), 32'(cnt));
    chk({tag, "_a_wr_ready"}, {31'd0, a_wr_ready}, {31'd0, rdy});
    chk({tag, "_b_wr_ready"}, {31'd0, b_wr_ready}, {31'd0, rdy});
    chk({tag, "_a_overflow"}, {31'd0, a_overflow}, {31'd0, ovf});
    chk({tag, "_b_overflow"}, {31'd0, b_overflow}, {31'd0, ovf});
    chk({tag, "_a_busy"}, {31'd0, a_busy}, {31'd0, bsy});
    chk({tag, "_b_busy"}, {31'd0, b_busy}, {31'd0, bsy});
  endtask

  // Wait for every expected byte, then for the sender to come back, then one
  // more edge for the serialiser to settle into idle.
  task automatic drain(input string tag, input logic ovf);
    int n = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_a_left"}, 32'(exp_a_q.size()), 32'd0);
    chk({tag, "_b_left"}, 32'(exp_b_q.size()), 32'd0);
    step();
    n = 0;
    while (!sender_ready && n < 50) begin
      step();
      n++;
    end
    step();
    check_status({tag, "_idle"}, 0, 1'b1, ovf, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          bo;
    int            wcyc;
    int            base;
    int            i;
    int            n;

    // Reset state.
    steps(2);
    check_status("reset", 0, 1'b1, 1'b0, 1'b0);
    chk("reset_a_data", {24'd0, a_sender_data}, 32'd0);
    chk("reset_a_enable", {31'd0, a_sender_enable}, 32'd0);
    reset_n = 1'b1;
    steps(3);

    // 1: MSB/LSB word order and first-pulse latency.
    max_gap = 1;
    first_pulse_cyc = -1;
    wcyc = cyc + 1;
    model_push(32'h4142_4344, 1'b0);
    write_raw(32'h4142_4344, 1'b0);
    drain("t1", 1'b0);
    chk("t1_latency", 32'(first_pulse_cyc - wcyc), 32'd3);

    // 2: byte-only word followed by a normal word.
    max_gap = 3;
    write_word(32'hDEAD_BE55, 1'b1);
    write_word(32'h1122_3344, 1'b0);
    drain("t2", 1'b0);

    // 3: fill with the sender stalled; the sixth write overflows.
    hold_ready = 1'b1;
    steps(4);
    for (int k = 0; k < 6; k++) begin
      d = $urandom;
      if (k == 5) begin
        chk("t3_full_ready", {31'd0, a_wr_ready}, 32'd0);
        chk("t3_pre_overflow", {31'd0, a_overflow}, 32'd0);
      end
      if (k < 5) model_push(d, 1'b0);
      write_raw(d, 1'b0);
    end
    check_status("t3_full", 4, 1'b0, 1'b1, 1'b1);
    chk("t3_a_state", 32'(a_dbg_state), 32'(ISSUE));
    hold_ready = 1'b0;
    drain("t3", 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_status("t3_flush", 0, 1'b1, 1'b0, 1'b0);

    // 4: stream 20 random words as fast as wr_ready allows.
    i = 0;
    n = 0;
    while (i < 20 && n < 2000) begin
      if (a_wr_ready) begin
        d  = $urandom;
        bo = ($urandom_range(3, 0) == 0);
        model_push(d, bo);
        wr_data      = d;
        wr_byte_only = bo;
        wr_enable    = 1'b1;
        i++;
      end else begin
        wr_enable = 1'b0;
      end
      step();
      chk("t4_a_count_bound", {31'd0, (a_count <= 4)}, 32'd1);
      n++;
    end
    wr_enable = 1'b0;
    chk("t4_all_written", 32'(i), 32'd20);
    drain("t4", 1'b0);

    // 5: flush after the second byte of a word with two more queued.
    max_gap = 1;
    base = pulse_cnt;
    write_word($urandom, 1'b0);
    write_word($urandom, 1'b0);
    write_word($urandom, 1'b0);
    n = 0;
    while (pulse_cnt < base + 2 && n < 300) begin
      step();
      n++;
    end
    chk("t5_two_pulses", 32'(pulse_cnt - base), 32'd2);
    flush     = 1'b1;
    wr_data   = $urandom;
    wr_enable = 1'b1;
    step();
    flush     = 1'b0;
    wr_enable = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    check_status("t5_flush", 0, 1'b1, 1'b0, 1'b0);
    steps(40);
    chk("t5_no_more_pulses", 32'(pulse_cnt - base), 32'd2);

    // 6: asynchronous reset while a word waits in ISSUE.
    max_gap = 2;
    write_word(32'hA5C3_3C5A, 1'b0);
    drain("t6_pre", 1'b0);
    hold_ready = 1'b1;
    steps(3);
    write_raw($urandom, 1'b0);
    write_raw($urandom, 1'b0);
    steps(3);
    chk("t6_a_state", 32'(a_dbg_state), 32'(ISSUE));
    chk("t6_b_state", 32'(b_dbg_state), 32'(ISSUE));
    chk("t6_a_count", 32'(a_count), 32'd1);
    chk("t6_a_data_held", {24'd0, a_sender_data}, 32'h5A);
    #2;
    reset_n = 1'b0;
    #1;
    check_status("t6_reset", 0, 1'b1, 1'b0, 1'b0);
    chk("t6_a_data", {24'd0, a_sender_data}, 32'd0);
    chk("t6_b_data", {24'd0, b_sender_data}, 32'd0);
    chk("t6_a_enable", {31'd0, a_sender_enable}, 32'd0);
    chk("t6_a_idle", 32'(a_dbg_state), 32'(IDLE));
    steps(2);
    reset_n = 1'b1;
    hold_ready = 1'b0;
    steps(4);
    write_word($urandom, 1'b0);
    drain("t6", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_word_tx_fifo.md
Name: uart_word_tx_fifo

Overview:
Parametrised successor to the single-word UART sender buffer. Queues up to 2**DEPTH_LOG2 words from the execution stage (RegtoUART path) and serialises each into bytes for the byte-wide UART sender. Adds configurable word width, depth and byte order, a per-word byte-only mode, flush, occupancy reporting and a sticky overflow flag.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8 and at least 8; NBYTES = DATA_WIDTH/8.
DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 entries; must be at least 1.
MSB_FIRST, 1, 1 sends byte NBYTES-1 first; 0 sends byte 0 first.

Ports:
CLK  in  1  system clock; all state updates on rising edge.
reset_n  in  1  asynchronous, active-low reset.
flush  in  1  synchronous clear of FIFO and serialiser.
wr_data  in  DATA_WIDTH  word to transmit.
wr_byte_only  in  1  when set with wr_enable, only wr_data[7:0] is sent.
wr_enable  in  1  write strobe; accepted only if wr_ready.
wr_ready  out  1  FIFO not full.
sender_ready  in  1  UART sender idle.
sender_data  out  8  byte presented to the sender.
sender_enable  out  1  one-cycle start pulse to the sender.
count  out  DEPTH_LOG2+1  number of stored words, excluding the word in the serialiser.
busy  out  1  serialiser holds a word, or count is nonzero.
overflow  out  1  sticky; set when a write is rejected.

Behaviour:
- Reset (reset_n low, asynchronous): FIFO empty, all pointers 0, state IDLE, sender_enable=0, sender_data=0, count=0, busy=0, overflow=0, wr_ready=1.
- Storage: circular buffer of {byte_only, data}.
  - Read and write pointers are DEPTH_LOG2+1 bits wide.
  - Full: low bits equal and MSBs differ. Empty: pointers equal. Pointers wrap modulo 2**(DEPTH_LOG2+1).
- Write: wr_enable && wr_ready stores the entry; visible in count the next cycle.
  - wr_enable while full: entry dropped, overflow set to 1.
  - overflow is cleared only by reset_n or flush.
- Simultaneous write and pop in one cycle: both take effect and count is unchanged. A write while full is rejected even if a pop occurs in the same cycle; wr_ready is registered from the current state.
- Serialiser FSM states: IDLE, LOAD, ISSUE, WAIT_BUSY, WAIT_READY.
  - IDLE: if FIFO is not empty, go to LOAD.
  - LOAD: pop the head into the shift register. Set bytes_left = 1 if byte_only, else NBYTES. Go to ISSUE.
  - ISSUE: when sender_ready=1, do all of the following in the same cycle:
    - drive sender_data with the current byte (MSB_FIRST selects the order; byte_only always sends [7:0]);
    - assert sender_enable for exactly this cycle;
    - shift the register and decrement bytes_left;
    - go to WAIT_BUSY.
  - ISSUE with sender_ready=0: hold, no pulse.
  - WAIT_BUSY: wait for sender_ready=0, then go to WAIT_READY. Its purpose is to tolerate the sender's one-cycle ready-drop latency.
  - WAIT_READY: wait for sender_ready=1. Then:
    - if bytes_left > 0, go to ISSUE;
    - else if the FIFO is not empty, go to LOAD;
    - else go to IDLE.
- Latency: a write into an empty, idle block with sender_ready=1 produces sender_enable on the 3rd rising edge after the write edge (write, LOAD, ISSUE).
- sender_data holds its last value between pulses.
- flush: overrides all other activity in that cycle.
  - Pointers reset, state returns to IDLE, overflow cleared, sender_enable=0.
  - Any write in the same cycle is discarded.
  - A byte already handed to the sender is not recalled.
- busy = (state != IDLE) || !empty.
- No combinational path from any input to any output.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum tx_state_t;
  - the function nbytes(DATA_WIDTH);
  - the localparam BYTE_W = 8.
- One sub-module, sync_fifo #(WIDTH, DEPTH_LOG2), is natural. It provides push, pop, full, empty, count and overflow, and is reused later for the receiver side.
- The serialiser FSM lives in uart_word_tx_fifo itself.

Test Plan:
1. Word order: DATA_WIDTH=32, MSB_FIRST=1; write 0x41424344 with sender_ready held 1 and the model dropping ready one cycle after each pulse. Required: pulses carry 0x41, 0x42, 0x43, 0x44; first pulse on the 3rd edge after the write; busy=0 after the last ready return.
2. Byte-only and LSB-first: MSB_FIRST=0; write 0xDEADBE55 with wr_byte_only=1, then 0x11223344 normal. Required sequence: 0x55, then 0x44, 0x33, 0x22, 0x11.
3. Full and overflow: DEPTH_LOG2=2, sender_ready=0; write 6 words.
   - After the first word moves into the serialiser, 4 more are accepted, count=4, wr_ready=0.
   - The 6th write sets overflow=1.
   - With sender_ready released, exactly 5 words are transmitted in order.
4. Wrap-around and simultaneous write/pop: stream 20 words with a write on every cycle that wr_ready allows. Required: all 20 words are transmitted in order with no loss; count never exceeds 4.
5. Flush mid-word: flush after the 2nd byte of a 4-byte word, with 2 words queued. Required: no further sender_enable; count=0; overflow=0; busy=0 one cycle later.
6. Reset mid-operation: pull reset_n low asynchronously between edges during ISSUE. Required: sender_enable=0 immediately, all outputs at reset values; after release, a new write is transmitted correctly.
